timestamp_controller_multi: RTL
===============================

Name: timestamp_controller_multi

Overview:
- Parametrised next-generation timestamp controller.
- Contains a COUNTER_WIDTH-bit free-running timestamp counter with a start/pause/reset/arm state machine, offset load, overflow flag and NUM_TRIG one-shot compare triggers.
- Controlled through a simple single-cycle register port, which the AXI slave front-end drives.
- Supplies the global timestamp and auto_start to downstream timed-output channels.

Parameters:
- COUNTER_WIDTH, 64, counter and register data width (>=8).
- NUM_TRIG, 4, number of compare/trigger channels (1..COUNTER_WIDTH).
- ADDR_WIDTH, 4, register address width; must satisfy 5+NUM_TRIG <= 2**ADDR_WIDTH.

Ports:
- s_axi_aclk  in  1  sole clock.
- s_axi_aresetn  in  1  asynchronous active-low reset.
- reg_wr_en  in  1  register write strobe, one cycle per write.
- reg_rd_en  in  1  register read strobe.
- reg_addr  in  ADDR_WIDTH  register address (word index).
- reg_wdata  in  COUNTER_WIDTH  write data.
- reg_rdata  out  COUNTER_WIDTH  read data.
- reg_rd_valid  out  1  read data valid pulse.
- sync_in  in  1  external start sync, synchronous to s_axi_aclk.
- counter  out  COUNTER_WIDTH  current timestamp (registered).
- auto_start  out  1  high while in RUNNING.
- overflow  out  1  sticky wrap flag.
- trig_out  out  NUM_TRIG  one-cycle trigger pulses.

Behaviour:
- Reset (s_axi_aresetn=0, asynchronous): state IDLE; counter, offset, cmp[*], trig_en, overflow, trig_out, reg_rdata, reg_rd_valid, auto_start and sync_in edge register all 0.
- Register map:
  - 0 CTRL (W): bit0 START, bit1 PAUSE, bit2 CLEAR, bit3 ARM.
  - 1 OFFSET (R/W).
  - 2 COUNTER snapshot (R).
  - 3 STATUS: R = {overflow, state[1:0]}; W bit2 = W1C overflow.
  - 4 TRIG_EN (R/W, bits NUM_TRIG-1:0).
  - 5+i CMP[i] (R/W).
  - Unmapped reads return 0; unmapped writes are ignored.
- Reads: reg_rd_valid and reg_rdata are registered one cycle after reg_rd_en. A read and write to the same address in the same cycle returns the old value.
- States: IDLE=0, ARMED=1, RUNNING=2, PAUSED=3.
- CTRL command priority within one write: CLEAR > PAUSE > START > ARM.
  - CLEAR: counter<=0 and state IDLE, from any state.
  - PAUSE: RUNNING->PAUSED, ARMED->IDLE; ignored otherwise.
  - START: IDLE/ARMED/PAUSED -> RUNNING; ignored in RUNNING.
  - ARM: IDLE/PAUSED -> ARMED.
- ARMED -> RUNNING on a sync_in rising edge (sync_in=1 and previous sample=0). The edge register samples continuously; a level already high at arm time does not start the counter.
- Counting: in RUNNING, counter increments by 1 per cycle and is held in every other state. The first increment occurs on the cycle after the state becomes RUNNING. auto_start = (state==RUNNING), registered.
- OFFSET write: counter<=wdata on the next edge in any state, overriding the increment that cycle. offset holds wdata. CLEAR in the same cycle wins over the offset load.
- Wrap: RUNNING with counter all-ones -> counter 0 and overflow<=1. Set wins over a simultaneous W1C.
- Triggers: trig_out[i] pulses for one cycle, registered, when state==RUNNING, trig_en[i]=1 and counter==cmp[i]. On firing, trig_en[i] auto-clears (one-shot). A TRIG_EN write in the same cycle as a fire: the write wins.
- Compare uses the present counter value, so trig_out[i] appears one cycle after counter equals cmp[i]. Equality reached via offset load while RUNNING fires; equality in PAUSED/IDLE does not.
- Multiple channels with equal cmp fire in the same cycle.

Test Plan:
- Reset mid-RUNNING (counter=0x55) -> all outputs 0 immediately, state IDLE; after release, counter holds 0 until START.
- Write CTRL=START; after 10 cycles write CTRL=PAUSE -> counter stops at a value between 9 and 11; auto_start falls one cycle after the pause is accepted; read COUNTER after 2 cycles returns the same value, rd_valid one cycle after rd_en.
- CTRL=ARM with sync_in held high, then low, then high -> no start on the held level; counter starts on the second rising edge, state reads 2.
- OFFSET=2^COUNTER_WIDTH-3, START -> wraps to 0 after 3 increments, overflow=1; W1C STATUS bit2 clears it; simultaneous wrap and W1C leaves overflow=1.
- cmp[0]=cmp[2]=20, cmp[1]=5, TRIG_EN=0b0111, START from 0 -> trig_out[1] pulses once after counter==5; trig_out[0] and trig_out[2] pulse together after counter==20; TRIG_EN reads 0 afterwards; no pulses on further passes.
- CTRL=0xF in IDLE with counter=7 -> CLEAR wins: counter 0, state IDLE.

Source files
------------

// File: rtl/timestamp_controller_multi.sv
// rtl/timestamp_controller_multi.sv - free-running timestamp counter with run-state FSM, offset load and one-shot compare triggers
module timestamp_controller_multi #(
  parameter int COUNTER_WIDTH = 64,
  parameter int NUM_TRIG      = 4,
  parameter int ADDR_WIDTH    = 4
) (
  input  logic                     s_axi_aclk,
  input  logic                     s_axi_aresetn,
  input  logic                     reg_wr_en,
  input  logic                     reg_rd_en,
  input  logic [ADDR_WIDTH-1:0]    reg_addr,
  input  logic [COUNTER_WIDTH-1:0] reg_wdata,
  output logic [COUNTER_WIDTH-1:0] reg_rdata,
  output logic                     reg_rd_valid,
  input  logic                     sync_in,
  output logic [COUNTER_WIDTH-1:0] counter,
  output logic                     auto_start,
  output logic                     overflow,
  output logic [NUM_TRIG-1:0]      trig_out
);

  localparam logic [ADDR_WIDTH-1:0] A_CTRL    = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_OFFSET  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_COUNTER = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS  = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_TRIG_EN = ADDR_WIDTH'(4);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RUNNING = 2'd2,
    PAUSED  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [COUNTER_WIDTH-1:0] counter_q, counter_d;
  logic [COUNTER_WIDTH-1:0] offset_q, offset_d;
  logic [COUNTER_WIDTH-1:0] cmp_q [NUM_TRIG];
  logic [COUNTER_WIDTH-1:0] cmp_d [NUM_TRIG];
  logic [NUM_TRIG-1:0]      trig_en_q, trig_en_d, trig_q, fire;
  logic                     overflow_q, overflow_d;
  logic                     auto_q, sync_prev_q, rd_valid_q;
  logic [COUNTER_WIDTH-1:0] rdata_q, rdata_d;

  logic ctrl_wr, offset_wr, status_wr, trig_en_wr;
  logic cmd_start, cmd_pause, cmd_clear, cmd_arm;
  logic running, sync_rise, wrap;

  assign ctrl_wr    = reg_wr_en && (reg_addr == A_CTRL);
  assign offset_wr  = reg_wr_en && (reg_addr == A_OFFSET);
  assign status_wr  = reg_wr_en && (reg_addr == A_STATUS);
  assign trig_en_wr = reg_wr_en && (reg_addr == A_TRIG_EN);

  assign cmd_start = ctrl_wr && reg_wdata[0];
  assign cmd_pause = ctrl_wr && reg_wdata[1];
  assign cmd_clear = ctrl_wr && reg_wdata[2];
  assign cmd_arm   = ctrl_wr && reg_wdata[3];

  assign running   = (state_q == RUNNING);
  assign sync_rise = sync_in && !sync_prev_q;
  // A wrap only counts when the increment actually happens (no load/clear override).
  assign wrap      = running && (counter_q == '1) && !offset_wr && !cmd_clear;

  always_comb begin
    state_d = state_q;
    if (state_q == ARMED && sync_rise) state_d = RUNNING;
    if (cmd_clear) begin
      state_d = IDLE;
    end else if (cmd_pause) begin
      if (state_q == RUNNING)    state_d = PAUSED;
      else if (state_q == ARMED) state_d = IDLE;
    end else if (cmd_start) begin
      if (state_q != RUNNING) state_d = RUNNING;
    end else if (cmd_arm) begin
      if (state_q == IDLE || state_q == PAUSED) state_d = ARMED;
    end
  end

  always_comb begin
    counter_d = counter_q;
    if (running)   counter_d = counter_q + COUNTER_WIDTH'(1);
    if (offset_wr) counter_d = reg_wdata;
    if (cmd_clear) counter_d = '0;
  end

  assign offset_d = offset_wr ? reg_wdata : offset_q;

  always_comb begin
    overflow_d = overflow_q;
    if (status_wr && reg_wdata[2]) overflow_d = 1'b0;
    if (wrap)                      overflow_d = 1'b1;
  end

  always_comb begin
    fire = '0;
    for (int i = 0; i < NUM_TRIG; i++) begin
      fire[i] = running && trig_en_q[i] && (counter_q == cmp_q[i]);
    end
  end

  // A firing channel disarms itself unless software rewrites TRIG_EN that cycle.
  assign trig_en_d = trig_en_wr ? reg_wdata[NUM_TRIG-1:0] : (trig_en_q & ~fire);

  always_comb begin
    for (int i = 0; i < NUM_TRIG; i++) begin
      cmp_d[i] = cmp_q[i];
      if (reg_wr_en && reg_addr == ADDR_WIDTH'(5 + i)) cmp_d[i] = reg_wdata;
    end
  end

  always_comb begin
    rdata_d = '0;
    case (reg_addr)
      A_OFFSET:  rdata_d = offset_q;
      A_COUNTER: rdata_d = counter_q;
      A_STATUS:  rdata_d[2:0] = {overflow_q, state_q};
      A_TRIG_EN: rdata_d[NUM_TRIG-1:0] = trig_en_q;
      default:   ;
    endcase
    for (int i = 0; i < NUM_TRIG; i++) begin
      if (reg_addr == ADDR_WIDTH'(5 + i)) rdata_d = cmp_q[i];
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q     <= IDLE;
      counter_q   <= '0;
      offset_q    <= '0;
      trig_en_q   <= '0;
      trig_q      <= '0;
      overflow_q  <= 1'b0;
      auto_q      <= 1'b0;
      sync_prev_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rdata_q     <= '0;
      for (int i = 0; i < NUM_TRIG; i++) cmp_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      offset_q    <= offset_d;
      trig_en_q   <= trig_en_d;
      trig_q      <= fire;
      overflow_q  <= overflow_d;
      auto_q      <= (state_d == RUNNING);
      sync_prev_q <= sync_in;
      rd_valid_q  <= reg_rd_en;
      if (reg_rd_en) rdata_q <= rdata_d;
      for (int i = 0; i < NUM_TRIG; i++) cmp_q[i] <= cmp_d[i];
    end
  end

  assign counter      = counter_q;
  assign auto_start   = auto_q;
  assign overflow     = overflow_q;
  assign trig_out     = trig_q;
  assign reg_rdata    = rdata_q;
  assign reg_rd_valid = rd_valid_q;

endmodule
